// File: rtl/axil_mitm_wr_if.sv
// AXI4-lite write-channel bundle (AW, W, B) shared by the upstream and downstream
// sides of the write interposer.
interface axil_mitm_wr_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_mitm_wr.sv
// AXI4-lite write-path interposer: every output comes straight from a flop and at
// most one write is in flight between the upstream master and downstream slave.
module axil_mitm_wr #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input logic            clk,
    input logic            rst,
    axil_mitm_wr_if.slave  s_axil,
    axil_mitm_wr_if.master m_axil
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t state_p0, state_nx;
    logic   aw_held_p0, aw_held_nx;
    logic   w_held_p0, w_held_nx;
    logic   s_awready_p0, s_awready_nx;
    logic   s_wready_p0, s_wready_nx;
    logic   s_bvalid_p0, s_bvalid_nx;
    logic   m_awvalid_p0, m_awvalid_nx;
    logic   m_wvalid_p0, m_wvalid_nx;
    logic   m_bready_p0, m_bready_nx;

    // Payload flops carry no reset; they only change on a handshake.
    logic [ADDR_WIDTH-1:0] awaddr_p0 = '0;
    logic [2:0]            awprot_p0 = '0;
    logic [DATA_WIDTH-1:0] wdata_p0  = '0;
    logic [STRB_WIDTH-1:0] wstrb_p0  = '0;
    logic [1:0]            bresp_p0  = '0;

    logic aw_hs, w_hs, b_hs;

    assign aw_hs = s_axil.awvalid && s_awready_p0;
    assign w_hs  = s_axil.wvalid && s_wready_p0;
    assign b_hs  = m_axil.bvalid && m_bready_p0;

    always_comb begin
        state_nx     = state_p0;
        aw_held_nx   = aw_held_p0;
        w_held_nx    = w_held_p0;
        s_awready_nx = 1'b0;
        s_wready_nx  = 1'b0;
        m_bready_nx  = 1'b0;
        m_awvalid_nx = m_awvalid_p0 && !m_axil.awready;
        m_wvalid_nx  = m_wvalid_p0 && !m_axil.wready;
        s_bvalid_nx  = s_bvalid_p0 && !s_axil.bready;

        case (state_p0)
            IDLE: begin
                aw_held_nx = aw_held_p0 || aw_hs;
                w_held_nx  = w_held_p0 || w_hs;
                if (aw_held_nx && w_held_nx) begin
                    m_awvalid_nx = 1'b1;
                    m_wvalid_nx  = 1'b1;
                    aw_held_nx   = 1'b0;
                    w_held_nx    = 1'b0;
                    state_nx     = RESP;
                end else begin
                    // Readies reopen only once the previous downstream beats have drained.
                    s_awready_nx = !aw_held_nx && !m_awvalid_nx && !m_wvalid_nx;
                    s_wready_nx  = !w_held_nx && !m_awvalid_nx && !m_wvalid_nx;
                end
            end
            RESP: begin
                if (b_hs) begin
                    s_bvalid_nx = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    m_bready_nx = !s_bvalid_nx;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= IDLE;
            aw_held_p0   <= 1'b0;
            w_held_p0    <= 1'b0;
            s_awready_p0 <= 1'b0;
            s_wready_p0  <= 1'b0;
            s_bvalid_p0  <= 1'b0;
            m_awvalid_p0 <= 1'b0;
            m_wvalid_p0  <= 1'b0;
            m_bready_p0  <= 1'b0;
        end else begin
            state_p0     <= state_nx;
            aw_held_p0   <= aw_held_nx;
            w_held_p0    <= w_held_nx;
            s_awready_p0 <= s_awready_nx;
            s_wready_p0  <= s_wready_nx;
            s_bvalid_p0  <= s_bvalid_nx;
            m_awvalid_p0 <= m_awvalid_nx;
            m_wvalid_p0  <= m_wvalid_nx;
            m_bready_p0  <= m_bready_nx;
        end
    end

    // Captured straight into the output flops: readies guarantee the m-side valids are low.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            awaddr_p0 <= s_axil.awaddr;
            awprot_p0 <= s_axil.awprot;
        end
        if (w_hs) begin
            wdata_p0 <= s_axil.wdata;
            wstrb_p0 <= s_axil.wstrb;
        end
        if (b_hs) begin
            bresp_p0 <= m_axil.bresp;
        end
    end

    assign s_axil.awready = s_awready_p0;
    assign s_axil.wready  = s_wready_p0;
    assign s_axil.bvalid  = s_bvalid_p0;
    assign s_axil.bresp   = bresp_p0;
    assign m_axil.awaddr  = awaddr_p0;
    assign m_axil.awprot  = awprot_p0;
    assign m_axil.awvalid = m_awvalid_p0;
    assign m_axil.wdata   = wdata_p0;
    assign m_axil.wstrb   = wstrb_p0;
    assign m_axil.wvalid  = m_wvalid_p0;
    assign m_axil.bready  = m_bready_p0;
endmodule

// File: tb/tb_axil_mitm_wr.sv
// Directed bench for axil_mitm_wr: single, split, backpressure, B stall, reset and
// back-to-back writes with hand-computed expectations.
module tb_axil_mitm_wr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    axil_mitm_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up ();
    axil_mitm_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dn ();

    axil_mitm_wr #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axil (up),
        .m_axil (dn)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl_zero(input string tag);
        chk({tag, "_awready"}, up.awready, 1'b0);
        chk({tag, "_wready"}, up.wready, 1'b0);
        chk({tag, "_bvalid"}, up.bvalid, 1'b0);
        chk({tag, "_m_awvalid"}, dn.awvalid, 1'b0);
        chk({tag, "_m_wvalid"}, dn.wvalid, 1'b0);
        chk({tag, "_m_bready"}, dn.bready, 1'b0);
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [2:0] p,
                               input logic [31:0] d, input logic [3:0] s);
        up.awaddr = a; up.awprot = p; up.awvalid = 1'b1;
        up.wdata = d; up.wstrb = s; up.wvalid = 1'b1;
    endtask

    task automatic wait_up_ready(input string tag);
        int n = 0;
        while (!(up.awready === 1'b1 && up.wready === 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready_timeout"}, up.awready & up.wready, 1'b1);
    endtask

    task automatic do_b(input string tag, input logic [1:0] resp);
        int n = 0;
        while (dn.bready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_bready_timeout"}, dn.bready, 1'b1);
        dn.bresp = resp;
        dn.bvalid = 1'b1;
        tick();
        dn.bvalid = 1'b0;
    endtask

    initial begin
        up.awaddr = '0; up.awprot = '0; up.awvalid = 1'b0;
        up.wdata = '0; up.wstrb = '0; up.wvalid = 1'b0; up.bready = 1'b1;
        dn.awready = 1'b1; dn.wready = 1'b1; dn.bresp = '0; dn.bvalid = 1'b0;

        // Reset
        tick(); tick();
        chk_ctrl_zero("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_awready", up.awready, 1'b1);
        chk("post_reset_wready", up.wready, 1'b1);

        // 1: single write, both beats in one cycle
        drive_write(32'h1000, 3'b000, 32'hDEADBEEF, 4'hF);
        tick();
        up.awvalid = 1'b0; up.wvalid = 1'b0;
        chk("t1_m_awvalid", dn.awvalid, 1'b1);
        chk("t1_m_wvalid", dn.wvalid, 1'b1);
        chk("t1_m_awaddr", dn.awaddr, 32'h1000);
        chk("t1_m_wdata", dn.wdata, 32'hDEADBEEF);
        chk("t1_m_wstrb", dn.wstrb, 4'hF);
        chk("t1_s_awready", up.awready, 1'b0);
        tick();
        chk("t1_drain_awvalid", dn.awvalid, 1'b0);
        chk("t1_drain_wvalid", dn.wvalid, 1'b0);
        chk("t1_m_bready", dn.bready, 1'b1);
        do_b("t1", 2'b00);
        chk("t1_s_bvalid", up.bvalid, 1'b1);
        chk("t1_s_bresp", up.bresp, 2'b00);
        chk("t1_m_bready_drop", dn.bready, 1'b0);
        tick();
        chk("t1_s_bvalid_clr", up.bvalid, 1'b0);
        chk("t1_awready_back", up.awready, 1'b1);

        // 2: split beats, AW first then W three cycles later
        up.awaddr = 32'h2004; up.awprot = 3'b101; up.awvalid = 1'b1;
        tick();
        up.awvalid = 1'b0;
        chk("t2_awready_drop", up.awready, 1'b0);
        chk("t2_wready_c0", up.wready, 1'b1);
        chk("t2_no_m_awvalid", dn.awvalid, 1'b0);
        tick();
        chk("t2_wready_c1", up.wready, 1'b1);
        tick();
        chk("t2_wready_c2", up.wready, 1'b1);
        chk("t2_awready_c2", up.awready, 1'b0);
        up.wdata = 32'h12345678; up.wstrb = 4'h3; up.wvalid = 1'b1;
        tick();
        up.wvalid = 1'b0;
        chk("t2_m_awvalid", dn.awvalid, 1'b1);
        chk("t2_m_wvalid", dn.wvalid, 1'b1);
        chk("t2_m_awaddr", dn.awaddr, 32'h2004);
        chk("t2_m_awprot", dn.awprot, 3'b101);
        chk("t2_m_wdata", dn.wdata, 32'h12345678);
        chk("t2_m_wstrb", dn.wstrb, 4'h3);
        tick();
        do_b("t2", 2'b01);
        chk("t2_s_bresp", up.bresp, 2'b01);
        chk("t2_s_bvalid", up.bvalid, 1'b1);
        tick();

        // 3: downstream AW backpressure
        dn.awready = 1'b0;
        wait_up_ready("t3");
        drive_write(32'h3000, 3'b010, 32'hCAFEF00D, 4'hA);
        tick();
        up.awvalid = 1'b0; up.wvalid = 1'b0;
        chk("t3_m_wvalid_set", dn.wvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_m_awvalid_hold", dn.awvalid, 1'b1);
            chk("t3_m_awaddr_hold", dn.awaddr, 32'h3000);
            chk("t3_m_wvalid_clr", dn.wvalid, 1'b0);
            chk("t3_s_awready_low", up.awready, 1'b0);
            chk("t3_s_wready_low", up.wready, 1'b0);
        end
        dn.awready = 1'b1;
        tick();
        chk("t3_m_awvalid_clr", dn.awvalid, 1'b0);
        do_b("t3", 2'b00);
        chk("t3_s_bvalid", up.bvalid, 1'b1);
        tick();

        // 4: upstream B stall with a second write behind it
        up.bready = 1'b0;
        wait_up_ready("t4a");
        drive_write(32'h4000, 3'b000, 32'h11111111, 4'hF);
        tick();
        up.awvalid = 1'b0; up.wvalid = 1'b0;
        tick();
        do_b("t4a", 2'b00);
        chk("t4_first_bvalid", up.bvalid, 1'b1);
        tick();
        chk("t4_b2b_awready", up.awready, 1'b1);
        drive_write(32'h4004, 3'b000, 32'h22222222, 4'hF);
        tick();
        up.awvalid = 1'b0; up.wvalid = 1'b0;
        chk("t4_second_m_awaddr", dn.awaddr, 32'h4004);
        tick();
        dn.bresp = 2'b10; dn.bvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_m_bready_held", dn.bready, 1'b0);
            chk("t4_first_bvalid_held", up.bvalid, 1'b1);
            chk("t4_first_bresp_held", up.bresp, 2'b00);
        end
        up.bready = 1'b1;
        tick();
        chk("t4_first_accepted", up.bvalid, 1'b0);
        chk("t4_m_bready_open", dn.bready, 1'b1);
        tick();
        dn.bvalid = 1'b0;
        chk("t4_second_bvalid", up.bvalid, 1'b1);
        chk("t4_second_bresp", up.bresp, 2'b10);
        chk("t4_m_bready_drop", dn.bready, 1'b0);
        tick();

        // 5: reset while in RESP with downstream AW still pending
        dn.awready = 1'b0;
        wait_up_ready("t5");
        drive_write(32'h5000, 3'b000, 32'h55555555, 4'hF);
        tick();
        up.awvalid = 1'b0; up.wvalid = 1'b0;
        tick();
        chk("t5_pre_awvalid", dn.awvalid, 1'b1);
        chk("t5_pre_bready", dn.bready, 1'b1);
        rst = 1'b1;
        tick();
        chk_ctrl_zero("t5_reset");
        chk("t5_state_idle", dut.state_p0, 1'b0);
        rst = 1'b0;
        dn.awready = 1'b1;
        tick();
        chk("t5_ready_after", up.awready, 1'b1);
        drive_write(32'h6000, 3'b001, 32'hA5A5A5A5, 4'hC);
        tick();
        up.awvalid = 1'b0; up.wvalid = 1'b0;
        chk("t5_fresh_awaddr", dn.awaddr, 32'h6000);
        chk("t5_fresh_wdata", dn.wdata, 32'hA5A5A5A5);
        chk("t5_fresh_wstrb", dn.wstrb, 4'hC);
        tick();
        do_b("t5", 2'b11);
        chk("t5_fresh_bresp", up.bresp, 2'b11);
        tick();

        // 6: eight back-to-back writes
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            logic [1:0]  r;
            a = 32'h7000 + 32'(i * 4);
            d = 32'hF0F0F0F0 ^ (32'h01010101 * 32'(i));
            r = 2'(i);
            wait_up_ready("t6");
            drive_write(a, 3'(i), d, 4'(i + 1));
            tick();
            up.awvalid = 1'b0; up.wvalid = 1'b0;
            chk("t6_m_awaddr", dn.awaddr, a);
            chk("t6_m_wdata", dn.wdata, d);
            chk("t6_m_awvalid", dn.awvalid, 1'b1);
            chk("t6_one_outstanding", up.awready, 1'b0);
            tick();
            do_b("t6", r);
            chk("t6_s_bresp", up.bresp, r);
            chk("t6_s_bvalid", up.bvalid, 1'b1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
